// File: rtl/tt_sweep_capture_pkg.sv
// Shared definitions for the truth-table sweep/capture block.
//   N_IN_DEFAULT : default number of inputs of the swept combinational block
//   N_VEC        : number of vectors in a sweep at the default width
//   tt_state_t   : sweep controller states
package tt_pkg;

  localparam int N_IN_DEFAULT = 4;
  localparam int N_VEC        = 2**N_IN_DEFAULT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } tt_state_t;

endpackage

// File: rtl/tt_sweep_capture_if.sv
// Bundle between the sweep controller and its environment.
//   start          : sweep request (environment -> controller)
//   vec            : stimulus vector, vec[3]=a .. vec[0]=d (controller -> environment)
//   f_in, g_in     : swept block outputs (environment -> controller)
//   busy, done     : sweep status (controller -> environment)
//   f_table,g_table: captured truth tables, bit i = output for vec==i
// master is the sweep controller side, slave is the environment side.
interface tt_sweep_capture_if
  import tt_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT
);
  localparam int NV = 2**N_IN;

  logic            start;
  logic [N_IN-1:0] vec;
  logic            f_in;
  logic            g_in;
  logic            busy;
  logic            done;
  logic [NV-1:0]   f_table;
  logic [NV-1:0]   g_table;

  modport master (
    input  start, f_in, g_in,
    output vec, busy, done, f_table, g_table
  );

  modport slave (
    output start, f_in, g_in,
    input  vec, busy, done, f_table, g_table
  );

endinterface

// File: rtl/tt_sweep_capture_hold_counter.sv
// Per-vector dwell timer.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, count -> 0
//   clr  : restart the dwell at count 0
//   en   : advance the count; wraps to 0 after the last dwell cycle
//   last : high on the final dwell cycle of the current vector
module hold_counter #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  // At least one bit so HOLD_CYCLES=1 still has a legal (constant-zero) counter.
  localparam int              CW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]   TOP = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] count;

  assign last = (count == TOP);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// Truth-table sweep and capture stage for a small combinational block.
// On an accepted start it drives every input vector 0..2**N_IN-1 in
// ascending order, holds each for HOLD_CYCLES clocks and records f/g on
// the last hold cycle into f_table/g_table (bit i belongs to vector i).
//   clk : rising-edge clock
//   rst : synchronous active-high reset; abandons any sweep in progress
//   bus : master side of tt_sweep_capture_if (start, vec, f_in, g_in,
//         busy, done, f_table, g_table)
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int N_IN        = N_IN_DEFAULT,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  tt_sweep_capture_if.master  bus
);

  localparam int              VECS     = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(VECS - 1);

  tt_state_t       state;
  logic [N_IN-1:0] vec_r;
  logic            busy_r;
  logic            done_r;
  logic [VECS-1:0] f_tab;
  logic [VECS-1:0] g_tab;

  logic            start_ok;
  logic            drive;
  logic            last;

  // A request during a sweep is dropped, not queued.
  assign start_ok = bus.start && (state != DRIVE);
  assign drive    = (state == DRIVE);

  hold_counter #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_ok),
    .en   (drive),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      vec_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      f_tab  <= '0;
      g_tab  <= '0;
    end else if (start_ok) begin
      state  <= DRIVE;
      vec_r  <= '0;
      busy_r <= 1'b1;
      done_r <= 1'b0;
      f_tab  <= '0;
      g_tab  <= '0;
    end else if (drive && last) begin
      // The swept block is combinational, so its outputs already reflect
      // vec_r on the final hold cycle (even when HOLD_CYCLES is 1).
      f_tab[vec_r] <= bus.f_in;
      g_tab[vec_r] <= bus.g_in;
      if (vec_r == LAST_VEC) begin
        // vec stays on the final vector rather than wrapping.
        state  <= DONE;
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        vec_r <= vec_r + N_IN'(1);
      end
    end
  end

  assign bus.vec     = vec_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.f_table = f_tab;
  assign bus.g_table = g_tab;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: one instance with HOLD_CYCLES=2, one with
// HOLD_CYCLES=1, each driven by a behavioural stub of the swept block.
module tb_tt_sweep_capture;

  logic        clk;
  logic        rst;
  int          mode;
  logic [15:0] lut_f;
  logic [15:0] lut_g;
  int          total = 0;
  int          bad   = 0;

  tt_sweep_capture_if #(.N_IN(4)) bus2 ();
  tt_sweep_capture_if #(.N_IN(4)) bus1 ();

  tt_sweep_capture #(.N_IN(4), .HOLD_CYCLES(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  tt_sweep_capture #(.N_IN(4), .HOLD_CYCLES(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub of the swept block. mode 0: f=a&b g=c^d; 1: f=~(a|b|c|d) g=1;
  // 2: f=d g=c^d; otherwise lookup tables lut_f/lut_g.
  function automatic logic stub_f(input int m, input logic [3:0] v, input logic [15:0] lut);
    case (m)
      0:       return v[3] & v[2];
      1:       return ~(|v);
      2:       return v[0];
      default: return lut[v];
    endcase
  endfunction

  function automatic logic stub_g(input int m, input logic [3:0] v, input logic [15:0] lut);
    case (m)
      0, 2:    return v[1] ^ v[0];
      1:       return 1'b1;
      default: return lut[v];
    endcase
  endfunction

  always_comb begin
    bus2.f_in = stub_f(mode, bus2.vec, lut_f);
    bus2.g_in = stub_g(mode, bus2.vec, lut_g);
    bus1.f_in = stub_f(mode, bus1.vec, lut_f);
    bus1.g_in = stub_g(mode, bus1.vec, lut_g);
  end

  task automatic wait_done2(input string name);
    int k = 0;
    while (bus2.done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (bus2.done !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout done=%b required=1", name, bus2.done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus2.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus2.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b required=0", bus2.busy); end
    total++; if (bus2.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b required=0", bus2.done); end
    total++; if (bus2.vec !== 4'h0) begin bad++; $display("FAIL reset_vec got=%h required=0", bus2.vec); end
    total++; if (bus2.f_table !== 16'h0 || bus2.g_table !== 16'h0) begin
      bad++; $display("FAIL reset_tables got=%h/%h required=0/0", bus2.f_table, bus2.g_table);
    end
    total++; if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
      bad++; $display("FAIL reset_h1_status got=%b%b required=00", bus1.busy, bus1.done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep_hold2();
    int busy_cnt = 0;
    int done_at  = 0;
    mode = 0;
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      if (bus2.busy === 1'b1) busy_cnt++;
      if (bus2.done === 1'b1 && done_at == 0) done_at = n;
    end
    total++; if (busy_cnt != 32) begin bad++; $display("FAIL h2_busy_cycles got=%0d required=32", busy_cnt); end
    total++; if (done_at != 33) begin bad++; $display("FAIL h2_done_cycle got=%0d required=33", done_at); end
    total++; if (bus2.f_table !== 16'hF000) begin bad++; $display("FAIL h2_f_table got=%h required=F000", bus2.f_table); end
    total++; if (bus2.g_table !== 16'h6666) begin bad++; $display("FAIL h2_g_table got=%h required=6666", bus2.g_table); end
    total++; if (bus2.vec !== 4'hF) begin bad++; $display("FAIL h2_vec_hold got=%h required=f", bus2.vec); end
  endtask

  task automatic test_sweep_hold1();
    int busy_cnt = 0;
    int done_at  = 0;
    mode = 1;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      if (n > 1) @(negedge clk);
      if (bus1.busy === 1'b1) busy_cnt++;
      if (bus1.done === 1'b1 && done_at == 0) done_at = n;
    end
    total++; if (busy_cnt != 16) begin bad++; $display("FAIL h1_busy_cycles got=%0d required=16", busy_cnt); end
    total++; if (done_at != 17) begin bad++; $display("FAIL h1_done_cycle got=%0d required=17", done_at); end
    total++; if (bus1.f_table !== 16'h0001) begin bad++; $display("FAIL h1_f_table got=%h required=0001", bus1.f_table); end
    total++; if (bus1.g_table !== 16'hFFFF) begin bad++; $display("FAIL h1_g_table got=%h required=FFFF", bus1.g_table); end
    total++; if (bus2.f_table !== 16'hF000) begin bad++; $display("FAIL done_tables_stable got=%h required=F000", bus2.f_table); end
  endtask

  task automatic test_start_held();
    int vec_err = 0;
    mode = 0;
    bus2.start = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      // vector k occupies the two cycles 2k+1 and 2k+2 after the start edge
      if (bus2.busy !== 1'b1 || bus2.vec !== 4'((n - 1) / 2)) vec_err++;
    end
    total++; if (vec_err != 0) begin bad++; $display("FAIL held_vec_sequence got=%0d bad_cycles required=0", vec_err); end
    @(negedge clk);
    total++; if (bus2.done !== 1'b1 || bus2.busy !== 1'b0) begin
      bad++; $display("FAIL held_done got=%b%b required=busy0 done1", bus2.busy, bus2.done);
    end
    @(negedge clk);
    total++; if (bus2.busy !== 1'b1 || bus2.vec !== 4'h0 || bus2.done !== 1'b0 || bus2.f_table !== 16'h0) begin
      bad++; $display("FAIL held_restart got=busy%b vec%h done%b f%h required=busy1 vec0 done0 f0",
                      bus2.busy, bus2.vec, bus2.done, bus2.f_table);
    end
    bus2.start = 1'b0;
    wait_done2("held_second");
    total++; if (bus2.f_table !== 16'hF000 || bus2.g_table !== 16'h6666) begin
      bad++; $display("FAIL held_second_tables got=%h/%h required=F000/6666", bus2.f_table, bus2.g_table);
    end
  endtask

  task automatic test_rst_mid();
    int k = 0;
    mode = 0;
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    while (bus2.vec !== 4'h7 && k < 40) begin
      @(negedge clk);
      k++;
    end
    total++; if (bus2.vec !== 4'h7) begin bad++; $display("FAIL mid_reach_vec7 got=%h required=7", bus2.vec); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus2.vec !== 4'h0 || bus2.busy !== 1'b0 || bus2.done !== 1'b0) begin
      bad++; $display("FAIL mid_rst_status got=vec%h busy%b done%b required=vec0 busy0 done0",
                      bus2.vec, bus2.busy, bus2.done);
    end
    total++; if (bus2.f_table !== 16'h0 || bus2.g_table !== 16'h0) begin
      bad++; $display("FAIL mid_rst_tables got=%h/%h required=0/0", bus2.f_table, bus2.g_table);
    end
    mode  = 3;
    lut_f = 16'($urandom);
    lut_g = 16'($urandom);
    @(negedge clk);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    wait_done2("mid_after");
    total++; if (bus2.f_table !== lut_f || bus2.g_table !== lut_g) begin
      bad++; $display("FAIL mid_after_tables got=%h/%h required=%h/%h", bus2.f_table, bus2.g_table, lut_f, lut_g);
    end
  endtask

  task automatic test_restart_from_done();
    mode = 2;
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    total++; if (bus2.f_table !== 16'h0 || bus2.g_table !== 16'h0 || bus2.busy !== 1'b1 || bus2.done !== 1'b0) begin
      bad++; $display("FAIL restart_clear got=f%h g%h busy%b done%b required=f0 g0 busy1 done0",
                      bus2.f_table, bus2.g_table, bus2.busy, bus2.done);
    end
    wait_done2("restart");
    total++; if (bus2.f_table !== 16'hAAAA || bus2.g_table !== 16'h6666) begin
      bad++; $display("FAIL restart_tables got=%h/%h required=AAAA/6666", bus2.f_table, bus2.g_table);
    end
  endtask

  task automatic test_rst_and_start();
    rst = 1'b1;
    bus2.start = 1'b1;
    @(negedge clk);
    total++; if (bus2.busy !== 1'b0 || bus2.done !== 1'b0 || bus2.vec !== 4'h0 || bus2.f_table !== 16'h0) begin
      bad++; $display("FAIL rst_start_same got=busy%b done%b vec%h f%h required=busy0 done0 vec0 f0",
                      bus2.busy, bus2.done, bus2.vec, bus2.f_table);
    end
    rst = 1'b0;
    bus2.start = 1'b0;
    @(negedge clk);
    total++; if (bus2.busy !== 1'b0 || bus2.done !== 1'b0) begin
      bad++; $display("FAIL rst_start_idle got=busy%b done%b required=busy0 done0", bus2.busy, bus2.done);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int busy_cnt = 0;
      int done_at  = 0;
      mode  = 3;
      lut_f = 16'($urandom);
      lut_g = 16'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      bus2.start = 1'b1;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (bus2.busy === 1'b1) busy_cnt++;
        if (bus2.done === 1'b1 && done_at == 0) done_at = n;
        // requests arriving while a sweep runs must have no effect
        bus2.start = (n <= 32) ? 1'($urandom) : 1'b0;
      end
      total++; if (busy_cnt != 32 || done_at != 33) begin
        bad++; $display("FAIL rand%0d_timing got=busy%0d done_at%0d required=busy32 done_at33", it, busy_cnt, done_at);
      end
      total++; if (bus2.f_table !== lut_f || bus2.g_table !== lut_g) begin
        bad++; $display("FAIL rand%0d_tables got=%h/%h required=%h/%h", it, bus2.f_table, bus2.g_table, lut_f, lut_g);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    mode       = 0;
    lut_f      = 16'h0;
    lut_g      = 16'h0;
    bus2.start = 1'b0;
    bus1.start = 1'b0;
    test_reset();
    test_sweep_hold2();
    test_sweep_hold1();
    test_start_held();
    test_rst_mid();
    test_restart_from_done();
    test_rst_and_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
